// File: rtl/bcd3_to_bin.sv
// ---------------------------------------------------------------------------
// bcd3_to_bin
//   Sequential 3-digit packed BCD to 10-bit binary converter. Each accepted
//   value is folded MSD first, one digit per cycle, with
//   acc = acc*10 + digit. The result appears 3 cycles after acceptance.
//
//   Optional feature macro: BCD3_TO_BIN_CHECK_EN
//     defined   : a digit > 9 at acceptance gives err=1 and bin=0 for
//                 that conversion.
//     undefined : err is tied low. Out-of-range digits are used as-is,
//                 and the result wraps modulo 1024.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   D2/D1/D0 hold a value to convert
//   in_ready   converter idle and able to accept
//   D2,D1,D0   hundreds / tens / units digits
//   out_valid  bin/err hold a completed result
//   out_ready  consumer accepts the result
//   bin        binary result (held until the next completion)
//   err        invalid-digit flag (check build only)
// ---------------------------------------------------------------------------
module bcd3_to_bin (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] D2,
    input  logic [3:0] D1,
    input  logic [3:0] D0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] bin,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] d2_q, d1_q, d0_q;
    logic [9:0] acc;
    logic [9:0] acc_nxt;
    logic [1:0] step;
    logic [3:0] digit;
    logic [9:0] bin_q;

    // Digit for the current fold step, MSD first
    always_comb begin
        digit = 4'd0;
        case (step)
            2'd0:    digit = d2_q;
            2'd1:    digit = d1_q;
            2'd2:    digit = d0_q;
            default: digit = 4'd0;
        endcase
    end

    // acc*10 as shift-add; wraps modulo 1024 by construction
    assign acc_nxt = (acc << 3) + (acc << 1) + {6'd0, digit};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CONV;
            end
            CONV: begin
                if (step == 2'd2) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BCD3_TO_BIN_CHECK_EN
    logic bad_q;   // some digit out of range, captured at acceptance
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Datapath. bin only changes on the CONV -> DONE transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d2_q  <= 4'd0;
            d1_q  <= 4'd0;
            d0_q  <= 4'd0;
            acc   <= 10'd0;
            step  <= 2'd0;
            bin_q <= 10'd0;
`ifdef BCD3_TO_BIN_CHECK_EN
            bad_q <= 1'b0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d2_q <= D2;
                        d1_q <= D1;
                        d0_q <= D0;
                        acc  <= 10'd0;
                        step <= 2'd0;
`ifdef BCD3_TO_BIN_CHECK_EN
                        bad_q <= (D2 > 4'd9) || (D1 > 4'd9) || (D0 > 4'd9);
`endif
                    end
                end
                CONV: begin
                    acc  <= acc_nxt;
                    step <= step + 2'd1;
                    if (step == 2'd2) begin
`ifdef BCD3_TO_BIN_CHECK_EN
                        bin_q <= bad_q ? 10'd0 : acc_nxt;
                        err_q <= bad_q;
`else
                        bin_q <= acc_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bin = bin_q;

endmodule

// File: tb/tb_bcd3_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd3_to_bin
//   Directed and random stimulus for bcd3_to_bin. Results are compared
//   against a decimal arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bcd3_to_bin;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] D2 = 4'd0, D1 = 4'd0, D0 = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] bin;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd3_to_bin dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .D2(D2), .D1(D1), .D0(D0),
        .out_valid(out_valid), .out_ready(out_ready),
        .bin(bin), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain decimal weighting, wrapped to 10 bits
    function automatic int ref_bin(input int h, input int t, input int u);
`ifdef BCD3_TO_BIN_CHECK_EN
        if (h > 9 || t > 9 || u > 9) return 0;
`endif
        return (h * 100 + t * 10 + u) % 1024;
    endfunction

    function automatic int ref_err(input int h, input int t, input int u);
`ifdef BCD3_TO_BIN_CHECK_EN
        return (h > 9 || t > 9 || u > 9) ? 1 : 0;
`else
        if (h + t + u < 0) return 1;   // never taken; keeps the args used
        return 0;
`endif
    endfunction

    // One full conversion: accept, check 3-cycle latency, hold for 'stall'
    // cycles with out_ready low, then handshake and check the return to IDLE.
    task automatic convert(input int h, input int t, input int u, input int stall);
        int n;
        int exp_b;
        exp_b = ref_bin(h, t, u);
        @(negedge clk);
        chk("idle_ready", int'(in_ready), 1);
        D2 = 4'(h); D1 = 4'(t); D0 = 4'(u);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_ready", int'(in_ready), 0);
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        chk("latency", n, 3);
        chk("bin", int'(bin), exp_b);
        chk("err", int'(err), ref_err(h, t, u));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_bin", int'(bin), exp_b);
            chk("hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", int'(out_valid), 0);
        chk("post_ready", int'(in_ready), 1);
        chk("post_bin", int'(bin), exp_b);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_bin", int'(bin), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(0, 0, 0, 0);
        convert(1, 9, 9, 0);
        convert(9, 9, 9, 0);
        convert(4, 2, 7, 6);

        // Inputs changed during CONV are ignored; new value taken next IDLE
        @(negedge clk);
        D2 = 4'd0; D1 = 4'd5; D0 = 4'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        D2 = 4'd8; D1 = 4'd8; D0 = 4'd8;
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        chk("chg_lat", n, 3);
        chk("chg_bin", int'(bin), 53);
        @(posedge clk); #1;       // handshake
        chk("chg_idle", int'(in_ready), 1);
        @(posedge clk); #1;       // 888 accepted here
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        chk("chg2_lat", n, 3);
        chk("chg2_bin", int'(bin), 888);
        @(posedge clk); #1;
        out_ready = 1'b0;

        convert(0, 10, 0, 1);
        convert(15, 15, 15, 0);

        // Reset during the last fold step of 5/5/5
        @(negedge clk);
        D2 = 4'd5; D1 = 4'd5; D0 = 4'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", int'(in_ready), 1);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_bin", int'(bin), 0);
        chk("arst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(3, 1, 4, 0);

        for (int k = 0; k < 25; k++)
            convert(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
